// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: forward-select bundle, RV32I base opcodes and the
// immediate format selector used by the immediate generator.
package decode_stage_pkg;

  // One-hot forward select for a source operand; all-zero means register-file data.
  typedef struct packed {
    logic ex;
    logic mem0;
    logic mem1;
  } fwd_type_t;

  // RV32I base opcodes (insn[6:0]).
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32 immediate generator.
// Ports:
//   insn - instruction word
//   fmt  - immediate format selected by the decoder
//   imm  - sign-extended 32-bit immediate (0 for IMM_NONE)
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] insn,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I:   imm = {{20{insn[31]}}, insn[31:20]};
      IMM_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U:   imm = {insn[31:12], 12'b0};
      IMM_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage between fetch and execute.
// Holds the fetched instruction in an instruction register (IR), exposes gated source indices
// to the forwarding unit / register file, resolves operands from register file or forwarded
// results, and registers a decoded bundle for execute. Load-use stalls insert bubbles, flush
// clears both the IR and the execute-bound register.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   fe_valid/fe_pc/fe_insn     - fetch handshake and payload; de_ready accepts it
//   flush                      - kill IR and execute register on the next edge
//   ex_ready                   - execute can take a new bundle
//   de_rs1/de_rs2              - source indices (0 when unused or IR empty)
//   fwd_stall, fwd_rs1/fwd_rs2 - hazard stall and one-hot forward selects
//   rf_*_data, *_fwd_data      - register-file and forwarded operand sources
//   de_ex_*                    - registered decoded bundle for execute
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        fe_valid,
  input  logic [31:0] fe_pc,
  input  logic [31:0] fe_insn,
  output logic        de_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic [4:0]  de_rs1,
  output logic [4:0]  de_rs2,
  input  logic        fwd_stall,
  input  fwd_type_t   fwd_rs1,
  input  fwd_type_t   fwd_rs2,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic [31:0] ex_fwd_data,
  input  logic [31:0] mem0_fwd_data,
  input  logic [31:0] mem1_fwd_data,
  output logic        de_ex_valid,
  output logic [31:0] de_ex_pc,
  output logic [31:0] de_ex_op1,
  output logic [31:0] de_ex_op2,
  output logic [31:0] de_ex_imm,
  output logic [4:0]  de_ex_wb_reg,
  output logic        de_ex_mem_read,
  output logic        de_ex_mem_write,
  output logic        de_ex_illegal,
  output logic [31:0] de_ex_insn
);

  // Instruction register
  logic        de_valid;
  logic [31:0] de_pc;
  logic [31:0] de_insn;

  logic        advance;
  logic [6:0]  opcode;
  logic        rs1_used;
  logic        rs2_used;
  logic        is_illegal;
  imm_fmt_t    imm_fmt;
  logic [31:0] imm;
  logic [4:0]  wb_reg;
  logic [31:0] op1;
  logic [31:0] op2;

  assign advance  = de_valid & ~fwd_stall & ex_ready;
  assign de_ready = ~de_valid | advance;
  assign opcode   = de_insn[6:0];

  // Format classification; unused sources are gated to x0 so the forwarding unit never
  // raises a stall on a register field that is really immediate bits.
  always_comb begin
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    is_illegal = 1'b0;
    imm_fmt    = IMM_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm_fmt = IMM_U;
      OPC_JAL:            imm_fmt = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        rs1_used = 1'b1;
        imm_fmt  = IMM_I;
      end
      OPC_STORE: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm_fmt  = IMM_S;
      end
      OPC_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm_fmt  = IMM_B;
      end
      OPC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: rs1_used = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  assign de_rs1 = (de_valid && rs1_used) ? de_insn[19:15] : 5'd0;
  assign de_rs2 = (de_valid && rs2_used) ? de_insn[24:20] : 5'd0;
  assign wb_reg = (opcode == OPC_STORE || opcode == OPC_BRANCH || is_illegal) ?
                  5'd0 : de_insn[11:7];

  decode_stage_imm_gen u_imm_gen (
    .insn (de_insn),
    .fmt  (imm_fmt),
    .imm  (imm)
  );

  // x0 (or a gated-off source) always reads as zero, whatever the forward select says.
  function automatic logic [31:0] pick_operand(input logic [4:0]  idx,
                                               input fwd_type_t   sel,
                                               input logic [31:0] rf_data,
                                               input logic [31:0] ex_data,
                                               input logic [31:0] m0_data,
                                               input logic [31:0] m1_data);
    if (idx == 5'd0)   return '0;
    else if (sel.ex)   return ex_data;
    else if (sel.mem0) return m0_data;
    else if (sel.mem1) return m1_data;
    else               return rf_data;
  endfunction

  assign op1 = pick_operand(de_rs1, fwd_rs1, rf_rs1_data, ex_fwd_data, mem0_fwd_data,
                            mem1_fwd_data);
  assign op2 = pick_operand(de_rs2, fwd_rs2, rf_rs2_data, ex_fwd_data, mem0_fwd_data,
                            mem1_fwd_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_valid <= 1'b0;
      de_pc    <= '0;
      de_insn  <= '0;
    end else if (flush) begin
      de_valid <= 1'b0;
    end else if (de_ready) begin
      de_valid <= fe_valid;
      if (fe_valid) begin
        de_pc   <= fe_pc;
        de_insn <= fe_insn;
      end
    end
  end

  // Execute register: loads only on advance, so forwarded data seen during a stall is
  // never latched as a valid operand. With ex_ready low everything holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_ex_valid     <= 1'b0;
      de_ex_pc        <= '0;
      de_ex_op1       <= '0;
      de_ex_op2       <= '0;
      de_ex_imm       <= '0;
      de_ex_wb_reg    <= '0;
      de_ex_mem_read  <= 1'b0;
      de_ex_mem_write <= 1'b0;
      de_ex_illegal   <= 1'b0;
      de_ex_insn      <= '0;
    end else if (flush) begin
      de_ex_valid <= 1'b0;
    end else if (ex_ready) begin
      de_ex_valid <= advance;
      if (advance) begin
        de_ex_pc        <= de_pc;
        de_ex_op1       <= op1;
        de_ex_op2       <= op2;
        de_ex_imm       <= imm;
        de_ex_wb_reg    <= wb_reg;
        de_ex_mem_read  <= (opcode == OPC_LOAD);
        de_ex_mem_write <= (opcode == OPC_STORE);
        de_ex_illegal   <= is_illegal;
        de_ex_insn      <= de_insn;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run against a
// behavioural model of the stage.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_insn;
  logic        de_ready;
  logic        flush;
  logic        ex_ready;
  logic [4:0]  de_rs1;
  logic [4:0]  de_rs2;
  logic        fwd_stall;
  fwd_type_t   fwd_rs1;
  fwd_type_t   fwd_rs2;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic [31:0] ex_fwd_data;
  logic [31:0] mem0_fwd_data;
  logic [31:0] mem1_fwd_data;
  logic        de_ex_valid;
  logic [31:0] de_ex_pc;
  logic [31:0] de_ex_op1;
  logic [31:0] de_ex_op2;
  logic [31:0] de_ex_imm;
  logic [4:0]  de_ex_wb_reg;
  logic        de_ex_mem_read;
  logic        de_ex_mem_write;
  logic        de_ex_illegal;
  logic [31:0] de_ex_insn;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] INSN_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] INSN_ADD  = 32'h0020_81B3;  // add x3,x1,x2
  localparam logic [31:0] INSN_LW   = 32'h0001_2083;  // lw x1,0(x2)
  localparam logic [31:0] INSN_LUI  = 32'h1234_52B7;  // lui x5,0x12345
  localparam logic [31:0] INSN_SW   = 32'hFE20_AE23;  // sw x2,-4(x1)
  localparam logic [31:0] INSN_BEQ  = 32'hFE20_8CE3;  // beq x1,x2,-8

  always #5 clk = ~clk;

  decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .fe_valid        (fe_valid),
    .fe_pc           (fe_pc),
    .fe_insn         (fe_insn),
    .de_ready        (de_ready),
    .flush           (flush),
    .ex_ready        (ex_ready),
    .de_rs1          (de_rs1),
    .de_rs2          (de_rs2),
    .fwd_stall       (fwd_stall),
    .fwd_rs1         (fwd_rs1),
    .fwd_rs2         (fwd_rs2),
    .rf_rs1_data     (rf_rs1_data),
    .rf_rs2_data     (rf_rs2_data),
    .ex_fwd_data     (ex_fwd_data),
    .mem0_fwd_data   (mem0_fwd_data),
    .mem1_fwd_data   (mem1_fwd_data),
    .de_ex_valid     (de_ex_valid),
    .de_ex_pc        (de_ex_pc),
    .de_ex_op1       (de_ex_op1),
    .de_ex_op2       (de_ex_op2),
    .de_ex_imm       (de_ex_imm),
    .de_ex_wb_reg    (de_ex_wb_reg),
    .de_ex_mem_read  (de_ex_mem_read),
    .de_ex_mem_write (de_ex_mem_write),
    .de_ex_illegal   (de_ex_illegal),
    .de_ex_insn      (de_ex_insn)
  );

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fe_valid      = 1'b0;
    fe_pc         = '0;
    fe_insn       = '0;
    flush         = 1'b0;
    ex_ready      = 1'b1;
    fwd_stall     = 1'b0;
    fwd_rs1       = '0;
    fwd_rs2       = '0;
    rf_rs1_data   = '0;
    rf_rs2_data   = '0;
    ex_fwd_data   = '0;
    mem0_fwd_data = '0;
    mem1_fwd_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] insn);
    fe_valid = 1'b1;
    fe_pc    = pc;
    fe_insn  = insn;
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct {
    logic        u1;
    logic        u2;
    logic [31:0] imm;
    logic [4:0]  wb;
    logic        mr;
    logic        mw;
    logic        ill;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] i);
    ref_t r;
    logic [31:0] v;
    r = '{u1: 1'b0, u2: 1'b0, imm: 32'd0, wb: i[11:7], mr: 1'b0, mw: 1'b0, ill: 1'b0};
    v = 32'd0;
    case (i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        r.u1 = 1'b1;
        v = 32'(i[31:20]);
        if (i[31]) v = v - 32'd4096;
        r.mr = (i[6:0] == OPC_LOAD);
      end
      OPC_STORE: begin
        r.u1 = 1'b1; r.u2 = 1'b1; r.wb = 5'd0; r.mw = 1'b1;
        v = 32'(i[31:25]) * 32 + 32'(i[11:7]);
        if (i[31]) v = v - 32'd4096;
      end
      OPC_BRANCH: begin
        r.u1 = 1'b1; r.u2 = 1'b1; r.wb = 5'd0;
        v = 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
        if (i[31]) v = v - 32'd4096;
      end
      OPC_LUI, OPC_AUIPC: v = 32'(i[31:12]) * 4096;
      OPC_JAL: begin
        v = 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048 + 32'(i[30:21]) * 2;
        if (i[31]) v = v - 32'h0010_0000;
      end
      OPC_OP: begin
        r.u1 = 1'b1; r.u2 = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: r.u1 = 1'b1;
      default: begin
        r.ill = 1'b1; r.wb = 5'd0;
      end
    endcase
    r.imm = v;
    return r;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] idx, input fwd_type_t f,
                                              input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (f.ex)        return ex_fwd_data;
    if (f.mem0)      return mem0_fwd_data;
    if (f.mem1)      return mem1_fwd_data;
    return rf;
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    feed(32'h44, INSN_ADD);
    tick();
    tick();
    checks++;
    if (de_ready !== 1'b1) begin
      errors++; $display("FAIL reset_de_ready got=%b exp=1", de_ready);
    end
    checks++;
    if ({de_ex_valid, de_ex_pc, de_ex_insn, de_ex_wb_reg} !== '0) begin
      errors++;
      $display("FAIL reset_ex_clear got valid=%b pc=%h insn=%h wb=%0d exp all 0",
               de_ex_valid, de_ex_pc, de_ex_insn, de_ex_wb_reg);
    end
    checks++;
    if (de_rs1 !== 5'd0 || de_rs2 !== 5'd0) begin
      errors++; $display("FAIL reset_rs got=%0d,%0d exp=0,0", de_rs1, de_rs2);
    end
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (de_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_de_ready got=%b exp=1", de_ready);
    end
  endtask

  task automatic test_addi();
    feed(32'h100, INSN_ADDI);
    rf_rs1_data = 32'hDEAD_BEEF;
    fwd_rs1     = '{ex: 1'b1, mem0: 1'b0, mem1: 1'b0};
    ex_fwd_data = 32'h1111;
    tick();
    fe_valid = 1'b0;
    #1;
    checks++;
    if (de_rs1 !== 5'd0 || de_rs2 !== 5'd0) begin
      errors++; $display("FAIL addi_rs got=%0d,%0d exp=0,0", de_rs1, de_rs2);
    end
    tick();
    checks++;
    if (de_ex_valid !== 1'b1 || de_ex_imm !== 32'd5 || de_ex_wb_reg !== 5'd1 ||
        de_ex_op1 !== 32'd0 || de_ex_pc !== 32'h100) begin
      errors++;
      $display("FAIL addi_bundle got v=%b imm=%h wb=%0d op1=%h pc=%h exp v=1 imm=5 wb=1 op1=0 pc=100",
               de_ex_valid, de_ex_imm, de_ex_wb_reg, de_ex_op1, de_ex_pc);
    end
    idle_inputs();
  endtask

  task automatic test_forward();
    feed(32'h200, INSN_ADD);
    tick();
    fe_valid      = 1'b0;
    fwd_rs1       = '{ex: 1'b1, mem0: 1'b0, mem1: 1'b0};
    fwd_rs2       = '{ex: 1'b0, mem0: 1'b0, mem1: 1'b1};
    ex_fwd_data   = 32'hAAAA;
    mem1_fwd_data = 32'h5555;
    mem0_fwd_data = 32'h7777;
    rf_rs1_data   = 32'h1;
    rf_rs2_data   = 32'h2;
    #1;
    checks++;
    if (de_rs1 !== 5'd1 || de_rs2 !== 5'd2) begin
      errors++; $display("FAIL fwd_rs got=%0d,%0d exp=1,2", de_rs1, de_rs2);
    end
    tick();
    checks++;
    if (de_ex_op1 !== 32'hAAAA || de_ex_op2 !== 32'h5555 || de_ex_wb_reg !== 5'd3) begin
      errors++;
      $display("FAIL fwd_ops got op1=%h op2=%h wb=%0d exp op1=aaaa op2=5555 wb=3",
               de_ex_op1, de_ex_op2, de_ex_wb_reg);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    feed(32'h300, INSN_LW);
    tick();
    feed(32'h304, INSN_ADD);
    tick();
    checks++;
    if (de_ex_valid !== 1'b1 || de_ex_mem_read !== 1'b1 || de_ex_wb_reg !== 5'd1) begin
      errors++;
      $display("FAIL lw_issue got v=%b mr=%b wb=%0d exp v=1 mr=1 wb=1",
               de_ex_valid, de_ex_mem_read, de_ex_wb_reg);
    end
    feed(32'h308, INSN_LUI);  // must not be captured while stalled
    fwd_stall     = 1'b1;
    mem0_fwd_data = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (de_ready !== 1'b0) begin
      errors++; $display("FAIL stall_de_ready got=%b exp=0", de_ready);
    end
    tick();
    checks++;
    if (de_ex_valid !== 1'b0) begin
      errors++; $display("FAIL stall_bubble got=%b exp=0", de_ex_valid);
    end
    fe_valid      = 1'b0;
    fwd_stall     = 1'b0;
    fwd_rs1       = '{ex: 1'b0, mem0: 1'b1, mem1: 1'b0};
    mem0_fwd_data = 32'hCAFE_0001;
    tick();
    checks++;
    if (de_ex_valid !== 1'b1 || de_ex_pc !== 32'h304 || de_ex_op1 !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL add_after_stall got v=%b pc=%h op1=%h exp v=1 pc=304 op1=cafe0001",
               de_ex_valid, de_ex_pc, de_ex_op1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lui();
    feed(32'h400, INSN_LW & 32'hFFFF_F07F | 32'h380);  // lw x7 into execute first
    tick();
    feed(32'h404, INSN_LUI);
    tick();
    fe_valid = 1'b0;
    #1;
    checks++;
    if (de_rs1 !== 5'd0 || de_rs2 !== 5'd0 || de_ready !== 1'b1) begin
      errors++;
      $display("FAIL lui_rs got rs1=%0d rs2=%0d rdy=%b exp 0 0 1", de_rs1, de_rs2, de_ready);
    end
    tick();
    checks++;
    if (de_ex_imm !== 32'h1234_5000 || de_ex_wb_reg !== 5'd5) begin
      errors++;
      $display("FAIL lui_bundle got imm=%h wb=%0d exp imm=12345000 wb=5", de_ex_imm, de_ex_wb_reg);
    end
    idle_inputs();
  endtask

  task automatic test_store_branch();
    feed(32'h500, INSN_SW);
    tick();
    feed(32'h504, INSN_BEQ);
    #1;
    checks++;
    if (de_rs1 !== 5'd1 || de_rs2 !== 5'd2) begin
      errors++; $display("FAIL sw_rs got=%0d,%0d exp=1,2", de_rs1, de_rs2);
    end
    tick();
    fe_valid = 1'b0;
    checks++;
    if (de_ex_imm !== 32'hFFFF_FFFC || de_ex_wb_reg !== 5'd0 || de_ex_mem_write !== 1'b1 ||
        de_ex_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL sw_bundle got imm=%h wb=%0d mw=%b mr=%b exp imm=fffffffc wb=0 mw=1 mr=0",
               de_ex_imm, de_ex_wb_reg, de_ex_mem_write, de_ex_mem_read);
    end
    tick();
    checks++;
    if (de_ex_imm !== 32'hFFFF_FFF8 || de_ex_wb_reg !== 5'd0 || de_ex_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL beq_bundle got imm=%h wb=%0d mw=%b exp imm=fffffff8 wb=0 mw=0",
               de_ex_imm, de_ex_wb_reg, de_ex_mem_write);
    end
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    feed(32'h600, INSN_ADDI);
    tick();
    feed(32'h604, INSN_ADD);
    tick();
    fe_valid  = 1'b0;
    ex_ready  = 1'b0;
    fwd_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (de_ex_valid !== 1'b1 || de_ex_pc !== 32'h600) begin
        errors++;
        $display("FAIL hold_%0d got v=%b pc=%h exp v=1 pc=600", k, de_ex_valid, de_ex_pc);
      end
    end
    ex_ready  = 1'b1;
    fwd_stall = 1'b0;
    tick();
    checks++;
    if (de_ex_valid !== 1'b1 || de_ex_pc !== 32'h604) begin
      errors++; $display("FAIL hold_release got v=%b pc=%h exp v=1 pc=604", de_ex_valid, de_ex_pc);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    feed(32'h700, INSN_ADDI);
    tick();
    feed(32'h704, INSN_ADD);
    tick();
    ex_ready = 1'b0;
    flush    = 1'b1;
    feed(32'h708, INSN_LUI);
    tick();
    idle_inputs();
    #1;
    checks++;
    if (de_ex_valid !== 1'b0 || de_ready !== 1'b1 || de_rs1 !== 5'd0) begin
      errors++;
      $display("FAIL flush_hold got v=%b rdy=%b rs1=%0d exp v=0 rdy=1 rs1=0",
               de_ex_valid, de_ready, de_rs1);
    end
    tick();
    checks++;
    if (de_ex_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop got v=%b exp=0", de_ex_valid);
    end
    // flush together with an advance: nothing issues
    feed(32'h710, INSN_ADDI);
    tick();
    fe_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (de_ex_valid !== 1'b0) begin
      errors++; $display("FAIL flush_vs_advance got v=%b exp=0", de_ex_valid);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    feed(32'h800, INSN_LW);
    tick();
    feed(32'h804, INSN_ADD);
    tick();
    fe_valid  = 1'b0;
    fwd_stall = 1'b1;
    #2;
    reset = 1'b1;  // between edges
    #1;
    checks++;
    if (de_ex_valid !== 1'b0 || de_ex_pc !== 32'd0 || de_ready !== 1'b1 || de_rs1 !== 5'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b pc=%h rdy=%b rs1=%0d exp v=0 pc=0 rdy=1 rs1=0",
               de_ex_valid, de_ex_pc, de_ready, de_rs1);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    logic [6:0]  opcs [14] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM,
                                7'h7F, 7'h00, 7'h0B};
    logic        m_v;
    logic [31:0] m_pc, m_insn;
    logic        x_v;
    logic [167:0] x_bundle, got_bundle;
    ref_t        d;
    logic [4:0]  e1, e2;
    logic        adv, rdy;
    logic [31:0] r;
    int          sel;
    do_reset();
    m_v = 1'b0; m_pc = '0; m_insn = '0; x_v = 1'b0; x_bundle = '0;
    for (int n = 0; n < 400; n++) begin
      r        = $urandom();
      fe_valid = ($urandom_range(0, 3) != 0);
      fe_pc    = {$urandom_range(0, 65535), 2'b00};
      fe_insn  = {r[31:7], opcs[$urandom_range(0, 13)]};
      flush    = ($urandom_range(0, 19) == 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      fwd_stall = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 3);
      fwd_rs1 = '{ex: sel == 1, mem0: sel == 2, mem1: sel == 3};
      sel = $urandom_range(0, 3);
      fwd_rs2 = '{ex: sel == 1, mem0: sel == 2, mem1: sel == 3};
      rf_rs1_data   = $urandom();
      rf_rs2_data   = $urandom();
      ex_fwd_data   = $urandom();
      mem0_fwd_data = $urandom();
      mem1_fwd_data = $urandom();
      #1;
      d   = ref_decode(m_insn);
      e1  = (m_v && d.u1) ? m_insn[19:15] : 5'd0;
      e2  = (m_v && d.u2) ? m_insn[24:20] : 5'd0;
      adv = m_v && !fwd_stall && ex_ready;
      rdy = !m_v || adv;
      checks++;
      if (de_ready !== rdy || de_rs1 !== e1 || de_rs2 !== e2) begin
        errors++;
        $display("FAIL rand_comb cyc=%0d got rdy=%b rs1=%0d rs2=%0d exp rdy=%b rs1=%0d rs2=%0d",
                 n, de_ready, de_rs1, de_rs2, rdy, e1, e2);
      end
      if (flush) begin
        x_v = 1'b0;
        m_v = 1'b0;
      end else begin
        if (ex_ready) begin
          x_v = adv;
          if (adv)
            x_bundle = {m_pc, ref_operand(e1, fwd_rs1, rf_rs1_data),
                        ref_operand(e2, fwd_rs2, rf_rs2_data), d.imm, d.wb,
                        d.mr, d.mw, d.ill, m_insn};
        end
        if (rdy) begin
          m_v = fe_valid;
          if (fe_valid) begin
            m_pc   = fe_pc;
            m_insn = fe_insn;
          end
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (de_ex_valid !== x_v) begin
        errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", n, de_ex_valid, x_v);
      end
      if (x_v) begin
        got_bundle = {de_ex_pc, de_ex_op1, de_ex_op2, de_ex_imm, de_ex_wb_reg, de_ex_mem_read,
                      de_ex_mem_write, de_ex_illegal, de_ex_insn};
        checks++;
        if (got_bundle !== x_bundle) begin
          errors++;
          $display("FAIL rand_bundle cyc=%0d got=%h exp=%h", n, got_bundle, x_bundle);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_lui();
    test_store_branch();
    test_stall_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode pipeline stage between fetch and execute. Holds the fetched instruction and extracts register indices for the forwarding unit. Selects operands from the register file or from forwarded execute/memory results, and generates the immediate. Registers a decoded bundle for execute, inserting bubbles on load-use stalls and clearing on flush.

## Interface
Parameters: none. All widths are fixed at RV32.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- fe_valid  in  1  fetch presents an instruction
- fe_pc  in  32  instruction PC
- fe_insn  in  32  instruction word
- de_ready  out  1  decode accepts fetch data this cycle
- flush  in  1  kill everything in decode and the execute-bound register
- ex_ready  in  1  execute can take a new bundle
- de_rs1, de_rs2  out  5  source indices to the forwarding unit and the register file read ports
- fwd_stall  in  1  load-use hazard on a used source
- fwd_rs1, fwd_rs2  in  fwd_type_t  one-hot {ex, mem0, mem1} forward select
- rf_rs1_data, rf_rs2_data  in  32  combinational register-file read data
- ex_fwd_data, mem0_fwd_data, mem1_fwd_data  in  32  forwardable results
- de_ex_valid  out  1  bundle valid
- de_ex_pc  out  32  PC of the bundle
- de_ex_op1, de_ex_op2  out  32  resolved rs1/rs2 values
- de_ex_imm  out  32  sign-extended immediate
- de_ex_wb_reg  out  5  destination; 0 when the instruction writes no register
- de_ex_mem_read, de_ex_mem_write  out  1  load or store
- de_ex_illegal  out  1  opcode not in RV32I base set
- de_ex_insn  out  32  raw instruction, for execute's funct decode

## Operation
- Instruction register (IR): holds de_valid, pc, insn.
- advance = de_valid & ~fwd_stall & ex_ready.
- de_ready = ~de_valid | advance. This is combinational; fetch data is captured when fe_valid & de_ready.
- If de_ready & ~fe_valid, de_valid clears.
- Source gating avoids false stalls:
  - de_rs1 = insn[19:15] for R, I, S, B formats; 0 for LUI, AUIPC, JAL.
  - de_rs2 = insn[24:20] for R, S, B formats; 0 otherwise.
  - Both are 0 when ~de_valid.
- Operand mux for each source: fwd.ex → ex_fwd_data; fwd.mem0 → mem0_fwd_data; fwd.mem1 → mem1_fwd_data; otherwise rf data. A gated-off or x0 source yields 0.
- Immediates:
  - I format: OP-IMM, LOAD, JALR.
  - S format: STORE.
  - B format: BRANCH.
  - U format: LUI, AUIPC.
  - J format: JAL.
  - All other opcodes: 0.
- wb_reg = rd, except 0 for STORE, BRANCH, and illegal opcodes.
- mem_read = (opcode == LOAD); mem_write = (opcode == STORE).
- Execute register, updated only when ex_ready:
  - advance → load the decoded bundle, de_ex_valid = 1.
  - otherwise → de_ex_valid = 0 (bubble); other fields may hold stale values.
  - ~ex_ready → all fields hold.
- Flush has priority over everything. On the next edge, IR de_valid = 0 and de_ex_valid = 0, and fetch data presented in the flush cycle is dropped. de_ready stays combinational with the rule above.

## Timing
- Latency: one cycle from IR capture to the bundle being visible, and one cycle from IR to the execute register.
- Reset (asynchronous): IR and all de_ex_* outputs = 0. de_ready = 1 while in reset and afterwards until the first capture.
- fwd_stall held for N cycles → N bubbles into execute. The IR holds and the instruction issues on the first cycle fwd_stall = 0.
- ~ex_ready together with fwd_stall → the execute register holds, with no bubble overwriting.
- Simultaneous flush & advance → flush wins and nothing is issued.
- Reset asserted mid-stall → state clears immediately, with no clock edge required.
- Forward data is only sampled in an advance cycle. Stale load data during a stall is never latched as valid.

## Structure
- Shared defines package holds:
  - fwd_type_t (packed {ex, mem0, mem1})
  - RV32I opcode localparams
  - imm_fmt_t enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}
- Sub-module imm_gen: combinational, (insn, imm_fmt_t) → 32-bit immediate.
- Format classification and the operand muxes stay inline.

## Test plan
- After reset, fe_valid=1, insn=0x00500093 (addi x1,x0,5), pc=0x100 → next cycle de_rs1=0 and de_rs2=0. The cycle after: de_ex_valid=1, imm=5, wb_reg=1, op1=0.
- IR holds add x3,x1,x2 with fwd_rs1.ex=1, fwd_rs2.mem1=1, ex=0xAAAA, mem1=0x5555 → op1=0xAAAA, op2=0x5555.
- fwd_stall high for 1 cycle on `lw` followed by `add` → exactly one bubble (de_ex_valid=0) and de_ready=0 that cycle. `add` issues the next cycle with mem0 data.
- lui x5,0x12345 while execute holds a load to x7 → de_rs1=0 and de_rs2=0, so no stall; imm=0x12345000.
- sw x2,-4(x1) → imm=0xFFFFFFFC, wb_reg=0, mem_write=1. beq with offset -8 → imm=0xFFFFFFF8.
- flush with IR valid and ex_ready=0 → next edge de_ex_valid=0 and IR empty. Asserting reset during a stall clears outputs asynchronously.
